hazard_scoreboard_unit: RTL and testbench

Parametrised hazard unit for the 5-stage RISC-V pipeline. It supports an iterative multi-cycle execute unit (mul/div) and keeps the existing duties: EX-stage operand forwarding, load-use stall, and branch flush. A small FSM holds the F/D/E stages and injects bubbles into M for a configurable EX occupancy. A saturating counter records front-end stall cycles for performance analysis.

---
 rtl/hazard_scoreboard_unit.sv | 131 +++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Hazard control for the 5-stage RISC-V pipeline with an iterative
// multi-cycle execute unit (mul/div).
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   rs1_d, rs2_d             sources of the instruction in D
//   rs1_e, rs2_e, rd_e       sources/destination of the instruction in E
//   rd_m, rd_w               destinations in M and W
//   reg_write_m/_w           M/W instruction writes the register file
//   result_src_e_lsb         E instruction is a load
//   pc_src_e                 taken branch/jump resolved in E
//   mc_start_e               multi-cycle op present in E (held while in E)
//   stall_f/_d/_e            hold PC, IF/ID, ID/EX
//   flush_d/_e               clear IF/ID, ID/EX
//   bubble_m                 clear EX/MEM
//   forward_a_e/_b_e         00 regfile, 01 W result, 10 M result
//   mc_busy, mc_done         FSM in BUSY / final EX cycle of the op
//   stall_cnt                saturating count of stall_f cycles
module hazard_scoreboard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic                  result_src_e_lsb,
  input  logic                  pc_src_e,
  input  logic                  mc_start_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  bubble_m,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned CW = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mc_hold;
  logic          lw;

  // cnt counts remaining BUSY cycles after the current one; loading
  // MC_LATENCY-3 yields MC_LATENCY-2 BUSY cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mc_start_e) begin
            cnt   <= CW'(MC_LATENCY - 3);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CW'(1);
        end
        DONE:    state <= IDLE;  // same op still in E; start is ignored
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          stall_cnt <= '0;
    else if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign mc_hold = ((state == IDLE) && mc_start_e) || (state == BUSY);
  assign lw      = result_src_e_lsb && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    bubble_m    = 1'b0;
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (!reset) begin
      if (reg_write_m && rd_m != '0 && rd_m == rs1_e)      forward_a_e = 2'b10;
      else if (reg_write_w && rd_w != '0 && rd_w == rs1_e) forward_a_e = 2'b01;
      if (reg_write_m && rd_m != '0 && rd_m == rs2_e)      forward_b_e = 2'b10;
      else if (reg_write_w && rd_w != '0 && rd_w == rs2_e) forward_b_e = 2'b01;

      if (mc_hold) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        bubble_m = 1'b1;
      end else if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign mc_busy = !reset && (state == BUSY);
  assign mc_done = !reset && (state == DONE);

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

  // packed observation: {sf,sd,se,fd,fe,bm, fa[1:0], fb[1:0], busy, done}
  localparam logic [11:0] Z     = 12'b000000_00_00_00;
  localparam logic [11:0] HOLD  = 12'b111001_00_00_00;
  localparam logic [11:0] HOLDB = 12'b111001_00_00_10;
  localparam logic [11:0] DONEV = 12'b000000_00_00_01;
  localparam logic [11:0] LU    = 12'b110010_00_00_00;
  localparam logic [11:0] BR    = 12'b000110_00_00_00;

  typedef struct {
    string       tag;
    int          inst;
    logic [11:0] v;
    logic [15:0] c;
  } exp_t;

  logic clk, reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic reg_write_m, reg_write_w, result_src_e_lsb, pc_src_e, mc_start_e;

  logic        sf0, sd0, se0, fd0, fe0, bm0, busy0, done0;
  logic [1:0]  fa0, fb0;
  logic [15:0] cnt0;
  logic        sf1, sd1, se1, fd1, fe1, bm1, busy1, done1;
  logic [1:0]  fa1, fb1;
  logic [15:0] cnt1;
  logic        sf2, sd2, se2, fd2, fe2, bm2, busy2, done2;
  logic [1:0]  fa2, fb2;
  logic [3:0]  cnt2;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_model[3];
  int   cnt_max[3] = '{65535, 65535, 15};

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .MC_LATENCY(4), .CNT_W(16)) u_l4 (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e_lsb(result_src_e_lsb), .pc_src_e(pc_src_e),
    .mc_start_e(mc_start_e), .stall_f(sf0), .stall_d(sd0), .stall_e(se0),
    .flush_d(fd0), .flush_e(fe0), .bubble_m(bm0), .forward_a_e(fa0),
    .forward_b_e(fb0), .mc_busy(busy0), .mc_done(done0), .stall_cnt(cnt0));

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .MC_LATENCY(3), .CNT_W(16)) u_l3 (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e_lsb(result_src_e_lsb), .pc_src_e(pc_src_e),
    .mc_start_e(mc_start_e), .stall_f(sf1), .stall_d(sd1), .stall_e(se1),
    .flush_d(fd1), .flush_e(fe1), .bubble_m(bm1), .forward_a_e(fa1),
    .forward_b_e(fb1), .mc_busy(busy1), .mc_done(done1), .stall_cnt(cnt1));

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .MC_LATENCY(4), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e_lsb(result_src_e_lsb), .pc_src_e(pc_src_e),
    .mc_start_e(mc_start_e), .stall_f(sf2), .stall_d(sd2), .stall_e(se2),
    .flush_d(fd2), .flush_e(fe2), .bubble_m(bm2), .forward_a_e(fa2),
    .forward_b_e(fb2), .mc_busy(busy2), .mc_done(done2), .stall_cnt(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
    rd_m = '0; rd_w = '0; reg_write_m = 0; reg_write_w = 0;
    result_src_e_lsb = 0; pc_src_e = 0; mc_start_e = 0;
  endtask

  task automatic expect_out(input string tag, input int inst, input logic [11:0] v);
    exp_t e;
    e.tag = tag; e.inst = inst; e.v = v; e.c = 16'(cnt_model[inst]);
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [11:0] ov;
    logic [15:0] oc;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected entry");
      return;
    end
    e = exp_q.pop_front();
    case (e.inst)
      0: begin ov = {sf0, sd0, se0, fd0, fe0, bm0, fa0, fb0, busy0, done0}; oc = cnt0; end
      1: begin ov = {sf1, sd1, se1, fd1, fe1, bm1, fa1, fb1, busy1, done1}; oc = cnt1; end
      default: begin ov = {sf2, sd2, se2, fd2, fe2, bm2, fa2, fb2, busy2, done2}; oc = {12'd0, cnt2}; end
    endcase
    checks++;
    assert (ov === e.v) else begin
      errors++;
      $error("FAIL %s outputs: observed %b expected %b", e.tag, ov, e.v);
    end
    checks++;
    assert (oc === e.c) else begin
      errors++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", e.tag, oc, e.c);
    end
    if (e.v[11] && cnt_model[e.inst] < cnt_max[e.inst]) cnt_model[e.inst]++;
  endtask

  task automatic step(input string tag, input int inst, input logic [11:0] v);
    expect_out(tag, inst, v);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    cnt_model = '{0, 0, 0};
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    cnt_model = '{0, 0, 0};
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_out("reset_state", 0, Z);
    check_now();
    reset = 1'b0;

    // forwarding priority
    rs1_e = 5; rs2_e = 5; rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1;
    step("fwd_m_prio", 0, 12'b000000_10_10_00);
    rd_m = 0;
    step("fwd_w", 0, 12'b000000_01_01_00);
    reg_write_w = 0;
    step("fwd_none", 0, Z);
    rs2_e = 6; rd_m = 6; reg_write_w = 1;
    step("fwd_mixed", 0, 12'b000000_01_10_00);
    rs1_e = 0; rs2_e = 0; rd_m = 0; rd_w = 0;
    step("fwd_x0", 0, Z);
    clear_inputs();

    // load-use
    result_src_e_lsb = 1; rd_e = 7; rs2_d = 7;
    step("load_use", 0, LU);
    rd_e = 0; rs2_d = 0;
    step("load_x0", 0, Z);
    result_src_e_lsb = 0;
    step("after_lu", 0, Z);

    // branch beats load-use
    result_src_e_lsb = 1; rd_e = 7; rs1_d = 7; pc_src_e = 1;
    step("branch_over_lu", 0, BR);
    clear_inputs();

    // multi-cycle op, MC_LATENCY=4, back-to-back, then load-use after DONE
    mc_start_e = 1;
    step("mc4_c1", 0, HOLD);
    step("mc4_c2", 0, HOLDB);
    pc_src_e = 1; result_src_e_lsb = 1; rd_e = 7; rs1_d = 7;
    step("mc4_c3_branch", 0, HOLDB);
    pc_src_e = 0; result_src_e_lsb = 0;
    step("mc4_done", 0, DONEV);
    step("mc4b_c1", 0, HOLD);
    step("mc4b_c2", 0, HOLDB);
    step("mc4b_c3", 0, HOLDB);
    step("mc4b_done", 0, DONEV);
    mc_start_e = 0; result_src_e_lsb = 1;
    step("lu_after_done", 0, LU);
    clear_inputs();
    step("mc4_idle", 0, Z);

    // multi-cycle op, MC_LATENCY=3
    do_reset();
    mc_start_e = 1;
    step("mc3_c1", 1, HOLD);
    step("mc3_c2", 1, HOLDB);
    step("mc3_done", 1, DONEV);
    mc_start_e = 0;
    step("mc3_idle", 1, Z);

    // asynchronous reset in the second BUSY cycle
    do_reset();
    mc_start_e = 1;
    step("rst_c1", 0, HOLD);
    step("rst_c2", 0, HOLDB);
    expect_out("rst_c3", 0, HOLDB);
    @(negedge clk);
    check_now();
    #2;
    reset = 1'b1;
    rs1_e = 5; rd_m = 5; reg_write_m = 1;
    #1;
    cnt_model = '{0, 0, 0};
    expect_out("async_reset", 0, Z);
    check_now();
    @(posedge clk);
    #1;
    rs1_e = 0; rd_m = 0; reg_write_m = 0;
    reset = 1'b0;
    step("restart_c1", 0, HOLD);
    step("restart_c2", 0, HOLDB);
    step("restart_c3", 0, HOLDB);
    step("restart_done", 0, DONEV);
    mc_start_e = 0;
    step("restart_idle", 0, Z);

    // saturation with CNT_W=4
    do_reset();
    result_src_e_lsb = 1; rd_e = 3; rs1_d = 3;
    for (int i = 0; i < 20; i++) step("sat_stall", 2, LU);
    clear_inputs();
    step("sat_hold", 2, Z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
